// File: rtl/ghost_otp_pkg.sv
// Shared types, sizing constants, id-tc26-Z S-boxes and Magma key schedule for the OTP keystream generator.
package ghost_otp_pkg;

    localparam int NIBBLES_PER_BLOCK = 16;
    localparam int BLOCKS_PER_PAD    = 64;
    localparam int ROUNDS            = 32;

    typedef enum logic [1:0] {
        IDLE,
        ENC,
        WRITE,
        DONE
    } state_t;

    // SBOX[i][n] is pi_i(n); row i substitutes nibble [4i+3:4i] of the round input.
    localparam logic [0:7][0:15][3:0] SBOX = {
        64'hC462A5B9E8D703F1,
        64'h68239A5C1E47BD0F,
        64'hB3582FADE174C960,
        64'hC821D4F670A53E9B,
        64'h7F5A816D093EB42C,
        64'h5DF692CAB78143E0,
        64'h8E25691CF4B0DA37,
        64'h17ED05834FA69CB2
    };

    // Rounds 0..23 cycle K1..K8 forwards, rounds 24..31 run K8..K1 (0 = K1).
    function automatic logic [2:0] key_index(input logic [4:0] rnd);
        return (rnd < 5'd24) ? rnd[2:0] : ~rnd[2:0];
    endfunction

    function automatic logic [31:0] round_key(input logic [255:0] key, input logic [4:0] rnd);
        logic [2:0] idx;
        idx = key_index(rnd);
        return key[32*(7 - int'(idx)) +: 32];
    endfunction

endpackage

// File: rtl/ghost_otp_keystream_magma_round.sv
// One combinational Magma round: g = rotl11(S(a0 + k)), then half swap (no swap on the final round).
module magma_round
    import ghost_otp_pkg::*;
(
    input  logic [63:0] blk_in,
    input  logic [31:0] key,
    input  logic        last,
    output logic [63:0] blk_out
);

    logic [31:0] a1;
    logic [31:0] a0;
    logic [31:0] sum;
    logic [31:0] sub;
    logic [31:0] g;

    assign a1  = blk_in[63:32];
    assign a0  = blk_in[31:0];
    assign sum = a0 + key;

    always_comb begin
        sub = '0;
        for (int i = 0; i < 8; i++) begin
            sub[4*i +: 4] = SBOX[i][sum[4*i +: 4]];
        end
    end

    assign g       = {sub[20:0], sub[31:21]};
    assign blk_out = last ? {g ^ a1, a0} : {a0, g ^ a1};

endmodule

// File: rtl/ghost_otp_keystream.sv
// Magma-CTR pad generator writing 1024 nibbles per request; 48 cycles per block (32 with OTP_TWO_ROUNDS_EN).
// No backpressure: the pad RAM accepts one write every cycle, odone flags a finished pad.
module ghost_otp_keystream
    import ghost_otp_pkg::*;
(
    input  logic         iclk,
    input  logic         irst,
    input  logic         istart,
    input  logic         inew_otp,
    input  logic [255:0] ikey,
    input  logic [31:0]  iIV,
    output logic [9:0]   oaddr,
    output logic [3:0]   owdata,
    output logic         owrite_en,
    output logic         odone
);

`ifdef OTP_TWO_ROUNDS_EN
    localparam int RND_STEP = 2;
`else
    localparam int RND_STEP = 1;
`endif

    state_t      state;
    state_t      state_nxt;
    logic [31:0] ctr;
    logic [31:0] pad_start;
    logic [31:0] start_ctr;
    logic [63:0] blk_q;
    logic [63:0] r0_out;
    logic [63:0] r_out;
    logic [31:0] key0;
    logic [5:0]  blk;
    logic [4:0]  rnd;
    logic [3:0]  nib;
    logic        enc_last;
    logic        nib_last;
    logic        blk_last;
    logic        last0;

    assign enc_last  = (rnd == 5'(ROUNDS - RND_STEP));
    assign nib_last  = (nib == 4'(NIBBLES_PER_BLOCK - 1));
    assign blk_last  = (blk == 6'(BLOCKS_PER_PAD - 1));
    assign start_ctr = inew_otp ? ctr : pad_start;
    assign key0      = round_key(ikey, rnd);

`ifdef OTP_TWO_ROUNDS_EN
    logic [31:0] key1;
    assign key1  = round_key(ikey, rnd + 5'd1);
    assign last0 = 1'b0;

    magma_round u_round1 (
        .blk_in  (r0_out),
        .key     (key1),
        .last    (enc_last),
        .blk_out (r_out)
    );
`else
    assign last0 = enc_last;
    assign r_out = r0_out;
`endif

    magma_round u_round0 (
        .blk_in  (blk_q),
        .key     (key0),
        .last    (last0),
        .blk_out (r0_out)
    );

    always_ff @(posedge iclk) begin
        if (irst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: if (istart) state_nxt = ENC;
            ENC:        if (enc_last) state_nxt = WRITE;
            WRITE:      if (nib_last) state_nxt = blk_last ? DONE : ENC;
            default:    state_nxt = IDLE;
        endcase
    end

    // blk_q holds the cipher state during ENC and doubles as the gamma shift register during WRITE.
    always_ff @(posedge iclk) begin
        if (irst) begin
            ctr       <= '0;
            pad_start <= '0;
            blk_q     <= '0;
            blk       <= '0;
            rnd       <= '0;
            nib       <= '0;
            oaddr     <= '0;
            owdata    <= '0;
            owrite_en <= 1'b0;
            odone     <= 1'b0;
        end else begin
            owrite_en <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (istart) begin
                        odone     <= 1'b0;
                        ctr       <= start_ctr;
                        pad_start <= start_ctr;
                        blk_q     <= {iIV, start_ctr};
                        blk       <= '0;
                        rnd       <= '0;
                    end
                end
                ENC: begin
                    blk_q <= r_out;
                    rnd   <= rnd + 5'(RND_STEP);
                    if (enc_last) begin
                        nib       <= '0;
                        owrite_en <= 1'b1;
                        oaddr     <= {blk, 4'h0};
                        owdata    <= r_out[63:60];
                    end
                end
                WRITE: begin
                    if (!nib_last) begin
                        nib       <= nib + 4'd1;
                        blk_q     <= {blk_q[59:0], 4'h0};
                        owrite_en <= 1'b1;
                        oaddr     <= {blk, nib + 4'd1};
                        owdata    <= blk_q[59:56];
                    end else begin
                        ctr <= ctr + 32'd1;
                        blk <= blk + 6'd1;
                        rnd <= '0;
                        if (blk_last) begin
                            odone <= 1'b1;
                        end else begin
                            blk_q <= {iIV, ctr + 32'd1};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ghost_otp_keystream.sv
// Directed bench for the Magma-CTR pad generator: known-answer block, full-pad reference model, rewind, ignore and reset cases.
module tb_ghost_otp_keystream;

`ifdef OTP_TWO_ROUNDS_EN
    localparam int PAD_CYCLES = 2048;
`else
    localparam int PAD_CYCLES = 3072;
`endif

    logic         iclk;
    logic         irst;
    logic         istart;
    logic         inew_otp;
    logic [255:0] ikey;
    logic [31:0]  iIV;
    logic [9:0]   oaddr;
    logic [3:0]   owdata;
    logic         owrite_en;
    logic         odone;

    int vectors;
    int miscompares;

    logic [3:0] pad_mem [1024];
    logic [3:0] pad_a   [1024];
    logic [3:0] pad_b   [1024];
    logic [9:0] exp_addr;
    int         wr_cnt;
    int         seq_err;

    logic [63:0] pi_rows [8] = '{
        64'hC462A5B9E8D703F1, 64'h68239A5C1E47BD0F, 64'hB3582FADE174C960, 64'hC821D4F670A53E9B,
        64'h7F5A816D093EB42C, 64'h5DF692CAB78143E0, 64'h8E25691CF4B0DA37, 64'h17ED05834FA69CB2
    };

    ghost_otp_keystream dut (
        .iclk      (iclk),
        .irst      (irst),
        .istart    (istart),
        .inew_otp  (inew_otp),
        .ikey      (ikey),
        .iIV       (iIV),
        .oaddr     (oaddr),
        .owdata    (owdata),
        .owrite_en (owrite_en),
        .odone     (odone)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    always @(negedge iclk) begin
        if (owrite_en === 1'b1) begin
            if (oaddr !== exp_addr) seq_err++;
            pad_mem[oaddr] = owdata;
            exp_addr = exp_addr + 10'd1;
            wr_cnt++;
        end
    end

    function automatic logic [31:0] m_g(input logic [31:0] a, input logic [31:0] k);
        logic [31:0] s;
        logic [31:0] t;
        logic [63:0] row;
        s = a + k;
        t = '0;
        for (int i = 0; i < 8; i++) begin
            row = pi_rows[i];
            t[4*i +: 4] = row[63 - 4*int'(s[4*i +: 4]) -: 4];
        end
        return (t << 11) | (t >> 21);
    endfunction

    function automatic logic [63:0] m_enc(input logic [255:0] key, input logic [63:0] blk);
        logic [31:0] kk [8];
        logic [31:0] a1;
        logic [31:0] a0;
        logic [31:0] t;
        logic [31:0] k;
        for (int i = 0; i < 8; i++) kk[i] = key[255 - 32*i -: 32];
        a1 = blk[63:32];
        a0 = blk[31:0];
        for (int r = 0; r < 32; r++) begin
            k = (r < 24) ? kk[r % 8] : kk[31 - r];
            t = m_g(a0, k) ^ a1;
            if (r < 31) begin
                a1 = a0;
                a0 = t;
            end else begin
                a1 = t;
            end
        end
        return {a1, a0};
    endfunction

    task automatic run_pad(input bit new_otp, input logic [31:0] start, input bit pulse, input string name);
        int          cnt;
        logic [63:0] got;
        logic [63:0] exp;
        for (int i = 0; i < 1024; i++) pad_mem[i] = 4'hx;
        wr_cnt   = 0;
        seq_err  = 0;
        exp_addr = '0;
        istart   = 1'b1;
        inew_otp = new_otp;
        @(negedge iclk);
        istart = 1'b0;
        cnt    = 0;
        while (odone !== 1'b1 && cnt < PAD_CYCLES + 64) begin
            if (pulse && (cnt == 3 || cnt == 20 || cnt == 40 || cnt == 700 || cnt == PAD_CYCLES - 3)) begin
                istart   = 1'b1;
                inew_otp = 1'b0;
            end else begin
                istart   = 1'b0;
                inew_otp = 1'b1;
            end
            @(negedge iclk);
            cnt++;
        end
        istart   = 1'b0;
        inew_otp = 1'b1;
        vectors++;
        if (cnt !== PAD_CYCLES) begin
            miscompares++;
            $display("FAIL %s done_latency: got %0d cycles, expected %0d", name, cnt, PAD_CYCLES);
        end
        vectors++;
        if (wr_cnt !== 1024) begin
            miscompares++;
            $display("FAIL %s write_count: got %0d, expected 1024", name, wr_cnt);
        end
        vectors++;
        if (seq_err !== 0) begin
            miscompares++;
            $display("FAIL %s addr_sequence: got %0d out-of-order writes, expected 0", name, seq_err);
        end
        for (int b = 0; b < 64; b++) begin
            got = '0;
            for (int j = 0; j < 16; j++) got = {got[59:0], pad_mem[16*b + j]};
            exp = m_enc(ikey, {iIV, start + 32'(b)});
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL %s block%0d: got %h, expected %h", name, b, got, exp);
            end
        end
    endtask

    function automatic int count_diff_a();
        int n;
        n = 0;
        for (int i = 0; i < 1024; i++) if (pad_mem[i] !== pad_a[i]) n++;
        return n;
    endfunction

    task automatic test_reset();
        irst = 1'b1;
        repeat (3) @(negedge iclk);
        vectors++;
        if (owrite_en !== 1'b0) begin miscompares++; $display("FAIL reset_write_en: got %b, expected 0", owrite_en); end
        vectors++;
        if (odone !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b, expected 0", odone); end
        vectors++;
        if (oaddr !== 10'd0) begin miscompares++; $display("FAIL reset_addr: got %h, expected 000", oaddr); end
        vectors++;
        if (owdata !== 4'd0) begin miscompares++; $display("FAIL reset_wdata: got %h, expected 0", owdata); end
        irst = 1'b0;
        @(negedge iclk);
    endtask

    task automatic test_first_pad();
        logic [63:0] got;
        run_pad(1'b1, 32'd0, 1'b0, "pad_ctr0");
        got = '0;
        for (int j = 0; j < 16; j++) got = {got[59:0], pad_mem[j]};
        vectors++;
        if (got !== 64'hdc46e167aba4b365) begin
            miscompares++;
            $display("FAIL known_answer_block0: got %h, expected dc46e167aba4b365", got);
        end
        pad_a = pad_mem;
    endtask

    task automatic test_fresh_pad();
        int n;
        run_pad(1'b1, 32'd64, 1'b0, "pad_ctr64");
        n = count_diff_a();
        vectors++;
        if (n == 0) begin
            miscompares++;
            $display("FAIL fresh_pad_differs: got %0d differing nibbles, expected nonzero", n);
        end
        pad_b = pad_mem;
    endtask

    task automatic test_rewind();
        int n;
        run_pad(1'b0, 32'd64, 1'b0, "pad_rewind");
        n = 0;
        for (int i = 0; i < 1024; i++) if (pad_mem[i] !== pad_b[i]) n++;
        vectors++;
        if (n !== 0) begin
            miscompares++;
            $display("FAIL rewind_identical: got %0d differing nibbles, expected 0", n);
        end
    endtask

    task automatic test_ignore_start();
        run_pad(1'b1, 32'd128, 1'b1, "pad_ignore_start");
    endtask

    task automatic test_reset_midpad();
        int cnt;
        int n;
        istart   = 1'b1;
        inew_otp = 1'b1;
        @(negedge iclk);
        istart = 1'b0;
        cnt    = 0;
        while (cnt < 500) begin
            @(negedge iclk);
            cnt++;
        end
        irst = 1'b1;
        @(negedge iclk);
        vectors++;
        if (owrite_en !== 1'b0) begin miscompares++; $display("FAIL midreset_write_en: got %b, expected 0", owrite_en); end
        vectors++;
        if (odone !== 1'b0) begin miscompares++; $display("FAIL midreset_done: got %b, expected 0", odone); end
        vectors++;
        if (oaddr !== 10'd0) begin miscompares++; $display("FAIL midreset_addr: got %h, expected 000", oaddr); end
        irst = 1'b0;
        repeat (3) @(negedge iclk);
        vectors++;
        if (owrite_en !== 1'b0 || odone !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_idle: got write_en %b done %b, expected 0 0", owrite_en, odone);
        end
        run_pad(1'b1, 32'd0, 1'b0, "pad_after_reset");
        n = count_diff_a();
        vectors++;
        if (n !== 0) begin
            miscompares++;
            $display("FAIL after_reset_matches_first: got %0d differing nibbles, expected 0", n);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        wr_cnt      = 0;
        seq_err     = 0;
        exp_addr    = '0;
        irst        = 1'b1;
        istart      = 1'b0;
        inew_otp    = 1'b1;
        ikey        = 256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
        iIV         = 32'h12345678;
        test_reset();
        test_first_pad();
        test_fresh_pad();
        test_rewind();
        test_ignore_start();
        test_reset_midpad();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
